// File: rtl/mul_div_unit.sv
// mul_div_unit: sequential multiply/divide unit for the multi-cycle ALU codes.
//   MUL (0100), UMULL (0101), SMULL (0110): radix-2 shift-add, one bit per cycle.
//   DIV (0111): restoring unsigned division, one quotient bit per cycle.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   start      - request pulse, sampled only in IDLE
//   ALUControl - operation code, latched with start
//   SrcA/SrcB  - multiplicand/multiplier or dividend/divisor
//   busy       - high from accepted start until done
//   done       - one-cycle completion pulse
//   ResultLo   - product low word / quotient
//   ResultHi   - product high word / remainder (zero for MUL)
//   ALUFlags   - {N,Z} of the completed result
//   DivZero    - high with done when the DIV divisor was zero
`timescale 1ns/1ps
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       ALUFlags,
    output logic             DivZero
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_UMULL = 4'b0101;
    localparam logic [3:0] OP_SMULL = 4'b0110;
    localparam logic [3:0] OP_DIV   = 4'b0111;

    typedef enum logic [1:0] {IDLE, MULT, DIVI, DONE} state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic [2*WIDTH-1:0] acc_q;    // multiply: {partial, multiplier}; divide: low word holds dividend/quotient
    logic [WIDTH-1:0]   mcand_q;  // multiplicand or divisor
    logic [WIDTH-1:0]   rem_q;
    logic [CW-1:0]      cnt_q;
    logic               sign_q;
    logic               last_q;   // all WIDTH iterations done; next edge writes results

    logic [WIDTH-1:0]   abs_a_d, abs_b_d;
    logic [WIDTH:0]     add_d;
    logic [2*WIDTH-1:0] mul_step_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     shl_d;
    logic               ge_d;
    logic [WIDTH-1:0]   rem_step_d;
    logic               dz_d;
    logic [WIDTH-1:0]   lo_d, hi_d;
    logic [1:0]         flags_d;

    always_comb begin
        abs_a_d = SrcA[WIDTH-1] ? -SrcA : SrcA;
        abs_b_d = SrcB[WIDTH-1] ? -SrcB : SrcB;

        // Shift-add step: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right with carry.
        add_d      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_step_d = {add_d, acc_q[WIDTH-1:1]};
        prod_d     = (op_q == OP_SMULL && sign_q) ? -acc_q : acc_q;

        // Restoring step on a WIDTH+1-bit partial remainder.
        shl_d      = {rem_q, acc_q[WIDTH-1]};
        ge_d       = shl_d >= {1'b0, mcand_q};
        rem_step_d = ge_d ? (shl_d[WIDTH-1:0] - mcand_q) : shl_d[WIDTH-1:0];

        dz_d = (op_q == OP_DIV) && (mcand_q == '0);

        lo_d = prod_d[WIDTH-1:0];
        hi_d = prod_d[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL: hi_d = '0;
            OP_DIV: begin
                lo_d = dz_d ? '1 : acc_q[WIDTH-1:0];
                hi_d = dz_d ? acc_q[WIDTH-1:0] : rem_q;
            end
            default: ;
        endcase

        if (op_q == OP_UMULL || op_q == OP_SMULL)
            flags_d = {hi_d[WIDTH-1], ({hi_d, lo_d} == '0)};
        else
            flags_d = {lo_d[WIDTH-1], (lo_d == '0)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            last_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ResultLo <= '0;
            ResultHi <= '0;
            ALUFlags <= '0;
            DivZero  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (ALUControl == OP_MUL || ALUControl == OP_UMULL ||
                                  ALUControl == OP_SMULL || ALUControl == OP_DIV)) begin
                        op_q   <= ALUControl;
                        cnt_q  <= '0;
                        last_q <= 1'b0;
                        rem_q  <= '0;
                        busy   <= 1'b1;
                        sign_q <= (ALUControl == OP_SMULL) ? (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) : 1'b0;
                        if (ALUControl == OP_SMULL) begin
                            mcand_q <= abs_a_d;
                            acc_q   <= {{WIDTH{1'b0}}, abs_b_d};
                        end else if (ALUControl == OP_DIV) begin
                            mcand_q <= SrcB;
                            acc_q   <= {{WIDTH{1'b0}}, SrcA};
                        end else begin
                            mcand_q <= SrcA;
                            acc_q   <= {{WIDTH{1'b0}}, SrcB};
                        end
                        state_q <= (ALUControl == OP_DIV) ? DIVI : MULT;
                    end
                end
                MULT, DIVI: begin
                    if (last_q || dz_d) begin
                        ResultLo <= lo_d;
                        ResultHi <= hi_d;
                        ALUFlags <= flags_d;
                        DivZero  <= dz_d;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        last_q   <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        if (state_q == MULT) begin
                            acc_q <= mul_step_d;
                        end else begin
                            rem_q <= rem_step_d;
                            acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge_d};
                        end
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            last_q <= 1'b1;
                            cnt_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    DivZero <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
`timescale 1ns/1ps
module tb_mul_div_unit;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_UMULL = 4'b0101;
    localparam logic [3:0] OP_SMULL = 4'b0110;
    localparam logic [3:0] OP_DIV   = 4'b0111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA, SrcB;
    logic        busy, done, DivZero;
    logic [31:0] ResultLo, ResultHi;
    logic [1:0]  ALUFlags;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] last_lo, last_hi;
    logic [1:0]  last_fl;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ResultLo(ResultLo), .ResultHi(ResultHi), .ALUFlags(ALUFlags), .DivZero(DivZero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: results straight from integer arithmetic on the operands.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic [1:0] fl, output logic dz);
        logic [63:0] p;
        longint sa, sb, sp;
        dz = 1'b0;
        case (op)
            OP_MUL: begin
                p = {32'd0, a} * {32'd0, b};
                lo = p[31:0];
                hi = 32'd0;
            end
            OP_UMULL: begin
                p = {32'd0, a} * {32'd0, b};
                {hi, lo} = p;
            end
            OP_SMULL: begin
                sa = $signed(a);
                sb = $signed(b);
                sp = sa * sb;
                {hi, lo} = sp;
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                    dz = 1'b1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
        if (op == OP_UMULL || op == OP_SMULL)
            fl = {hi[31], ({hi, lo} == 64'd0)};
        else
            fl = {lo[31], (lo == 32'd0)};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        logic [31:0] elo, ehi;
        logic [1:0]  efl;
        logic        edz;
        int          lat, exp_lat;
        bit          seen;
        model(op, a, b, elo, ehi, efl, edz);
        exp_lat = (op == OP_DIV && b == 32'd0) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        start = 1'b0;
        SrcA = $urandom; SrcB = $urandom;
        check("busy_accept", busy, 1);
        lat = 0; seen = 0;
        while (!seen && lat < 45) begin
            if (poke && lat == 5) begin
                start = 1'b1; ALUControl = OP_UMULL;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1;
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("lo", ResultLo, elo);
        check("hi", ResultHi, ehi);
        check("flags", ALUFlags, efl);
        check("divzero", DivZero, edz);
        check("busy_done", busy, 0);
        @(posedge clk); #1;
        check("done_clear", done, 0);
        check("dz_clear", DivZero, 0);
        check("lo_hold", ResultLo, elo);
        last_lo = elo; last_hi = ehi; last_fl = efl;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        reset = 1'b0; start = 1'b0; ALUControl = 4'd0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lo", ResultLo, 0);
        check("rst_hi", ResultHi, 0);
        check("rst_flags", ALUFlags, 0);
        check("rst_dz", DivZero, 0);
        @(negedge clk); reset = 1'b1;

        run_op(OP_MUL,   32'd7,         32'd6,         1'b0);
        run_op(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_SMULL, 32'hFFFF_FFFD, 32'd5,         1'b0);
        run_op(OP_SMULL, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(OP_DIV,   32'd100,       32'd7,         1'b0);
        run_op(OP_DIV,   32'd0,         32'd5,         1'b0);
        run_op(OP_DIV,   32'h1234_5678, 32'd0,         1'b0);
        run_op(OP_MUL,   32'd12345,     32'd678,       1'b1);

        // Illegal opcode with start must leave the unit idle and results held.
        @(negedge clk);
        start = 1'b1; ALUControl = 4'b0010; SrcA = 32'd9; SrcB = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        check("illegal_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_busy2", busy, 0);
        check("illegal_done", done, 0);
        check("illegal_lo", ResultLo, last_lo);
        check("illegal_hi", ResultHi, last_hi);
        check("illegal_flags", ALUFlags, last_fl);

        for (int i = 0; i < 40; i++) begin
            op = 4'b0100 + 4'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 255));
                2: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(op, a, b, i[0]);
        end

        // Asynchronous reset during iteration 10 of a divide.
        @(negedge clk);
        start = 1'b1; ALUControl = OP_DIV; SrcA = 32'hDEAD_BEEF; SrcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_lo", ResultLo, 0);
        check("arst_hi", ResultHi, 0);
        check("arst_flags", ALUFlags, 0);
        check("arst_dz", DivZero, 0);
        @(negedge clk); reset = 1'b1;
        run_op(OP_MUL, 32'd3, 32'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Sequential execution unit that services the multi-cycle ALUControl codes the decoder issues: MUL 4'b0100, UMULL 4'b0101, SMULL 4'b0110 and DIV 4'b0111.
- Sits beside the single-cycle ALU in the datapath; the controller holds its FSM while busy is high.
- Uses radix-2 shift-add for multiplies and restoring division for DIV, one bit per cycle.
- Drives a 64-bit result plus N/Z flags for condlogic.

Parameters:
WIDTH, 32, operand width; iteration count per operation

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request pulse; sampled only in IDLE
ALUControl  input  4  operation code; latched with start
SrcA  input  WIDTH  multiplicand / dividend
SrcB  input  WIDTH  multiplier / divisor
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse
ResultLo  output  WIDTH  MUL/UMULL/SMULL low word; DIV quotient
ResultHi  output  WIDTH  UMULL/SMULL high word; DIV remainder; MUL zero
ALUFlags  output  2  {N,Z} of the completed result
DivZero  output  1  high with done when DIV divisor was 0

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; busy=0, done=0, DivZero=0, ResultLo=0, ResultHi=0, ALUFlags=0, iteration counter=0.
- States: IDLE, MULT, DIVI, DONE.
- IDLE: start=1 with ALUControl in {0100,0101,0110} goes to MULT; with 0111 goes to DIVI. Any other code with start is ignored and the unit stays in IDLE. Operands and opcode are latched on this edge, E0. busy=1 from E0.
- MULT: unsigned shift-add on the 2*WIDTH accumulator, one multiplier bit per edge, edges E1..E_WIDTH.
  - SMULL: operands are replaced by their absolute values at E0; the sign = SrcA[MSB]^SrcB[MSB] is latched; the 64-bit product is two's-complement negated at the final edge if sign=1.
  - Absolute value of the most negative number (0x80000000) is 0x80000000 interpreted unsigned, which gives the correct result.
- DIVI: restoring division, one quotient bit per edge, E1..E_WIDTH; remainder is a WIDTH+1-bit partial. Divisor==0: skip iterations, go to DONE at E1 with ResultLo=all ones, ResultHi=dividend, DivZero=1.
- At edge E_(WIDTH+1) (E1 for divide-by-zero), result registers update and state=DONE:
  - busy=0, done=1 for exactly one cycle.
  - The next edge returns to IDLE with done=0 and DivZero=0.
- Outputs:
  - MUL: ResultLo = low WIDTH bits of the product; ResultHi=0.
  - ResultLo, ResultHi and ALUFlags hold their values until the next completion, including through the following idle period.
- Flags:
  - N = ResultHi[MSB] for UMULL/SMULL; N = ResultLo[MSB] for MUL/DIV.
  - Z = (full 2*WIDTH result==0) for long multiplies; Z = (ResultLo==0) for MUL/DIV.
- Timing and handshake:
  - start while busy or in DONE is ignored; there is no queuing. A new start is accepted in IDLE only, so back-to-back throughput is one operation per WIDTH+3 cycles.
  - Total latency is WIDTH+1 cycles from the accept edge to done (1 for divide-by-zero).
  - Operand inputs may change after E0 without effect.
- Reset mid-operation aborts immediately to the reset values; the partial result is discarded.
- Counter: log2(WIDTH)+1 bits; it terminates on count==WIDTH-1 at the iteration edge, with no wrap-around behaviour visible at the outputs.

Test Plan:
- MUL, SrcA=7, SrcB=6, start for one cycle → done exactly 33 cycles after the accept edge; ResultLo=0x0000002A, ResultHi=0, ALUFlags=2'b00.
- UMULL, 0xFFFFFFFF×0xFFFFFFFF → ResultHi=0xFFFFFFFE, ResultLo=0x00000001, N=1, Z=0.
- SMULL, 0xFFFFFFFD(−3)×0x00000005 → ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFF1, N=1. SMULL 0x80000000×0x80000000 → ResultHi=0x40000000, ResultLo=0.
- DIV, 100/7 → ResultLo=14, ResultHi=2, DivZero=0. DIV 0/5 → ResultLo=0, Z=1. DIV 0x12345678/0 → done one cycle after accept, ResultLo=0xFFFFFFFF, ResultHi=0x12345678, DivZero=1.
- start reasserted during MULT with different operands, and start with ALUControl=0010 in IDLE → both ignored; the first result is unaffected, and busy stays 0 for the illegal opcode.
- reset driven low at iteration 10 of a DIV → busy, done and all outputs 0 immediately, without waiting for a clock edge. Release reset, issue MUL 3×3 → ResultLo=9 after the normal latency.
